uart_regif_v2: RTL
==================

UART_REGIF_V2 -- requirements
Module: uart_regif_v2

Interface
REQ-001 Parameter DIV_W, default 16, divisor width; legal range 9..16; DLH bits above DIV_W-9 read 0.
REQ-002 Parameter DIV_RESET, default 1, divisor value loaded at reset; a divisor of 0 is never output.
REQ-003 Parameter SCR_EN, default 1; 1 = scratch register at addr 7 is implemented; 0 = addr 7 reads 0 and ignores writes.
REQ-004 Ports (direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-high.
- wr_en, in, 1: host write strobe.
- rd_en, in, 1: host read strobe.
- addr, in, 3: register address.
- data_in, in, 8: write data.
- rd_data, out, 8: read data.
- rd_valid, out, 1: rd_data valid.
- tx_fifo_full, in, 1: TX FIFO full.
- tx_fifo_empty, in, 1: TX FIFO empty.
- tx_busy, in, 1: TX shifter active.
- tx_wr_en, out, 1: TX FIFO push.
- tx_data, out, 8: TX FIFO push data.
- rx_fifo_empty, in, 1: RX FIFO empty.
- rx_data, in, 8: RX FIFO head (first-word-fall-through).
- rx_rd_en, out, 1: RX FIFO pop.
- rx_oe_p, in, 1: RX overrun pulse.
- rx_pe_p, in, 1: RX parity-error pulse.
- rx_fe_p, in, 1: RX framing-error pulse.
- tx_fifo_clr, out, 1: TX FIFO flush pulse.
- rx_fifo_clr, out, 1: RX FIFO flush pulse.
- divisor, out, DIV_W: baud divisor.
- lcr, out, 8: LCR contents.
- mcr, out, 8: MCR contents.
- irq, out, 1: interrupt request.

Function
REQ-005 Register map; DLAB = LCR[7]:
- addr 0: THR (write) / RBR (read) when DLAB=0; DLL when DLAB=1.
- addr 1: IER[3:0] when DLAB=0; DLH when DLAB=1.
- addr 2: IIR (read) / FCR (write).
- addr 3: LCR.
- addr 4: MCR.
- addr 5: LSR (read-only).
- addr 6: reads 0.
- addr 7: SCR.
REQ-006 When wr_en and rd_en are asserted together: write executes, read is ignored, rd_valid=0.
REQ-007 Read latency is 1 cycle: rd_valid is a 1-cycle pulse carrying rd_data; rd_data=0 whenever rd_valid=0.
REQ-008 THR write while tx_fifo_full=0: next cycle tx_wr_en=1 for exactly one cycle and tx_data=data_in.
REQ-009 THR write while tx_fifo_full=1: data is dropped, tx_wr_en stays 0, LSR[4] (TXOVF) is set.
REQ-010 RBR read while rx_fifo_empty=0: rd_data=rx_data sampled at the rd_en edge; rx_rd_en pulses once in the same cycle as rd_valid.
REQ-011 RBR read while rx_fifo_empty=1: rd_data=0, no pop.
REQ-012 divisor = {DLH,DLL} truncated to DIV_W bits; a DLL/DLH write that would make it 0 loads 1 instead.
REQ-013 FCR write: bit1 produces a 1-cycle rx_fifo_clr pulse; bit2 produces a 1-cycle tx_fifo_clr pulse; other bits are ignored.
REQ-014 LSR bit definitions:
- [0] DR = !rx_fifo_empty.
- [1] OE, [2] PE, [3] FE, [4] TXOVF: sticky bits.
- [5] THRE = !tx_fifo_full.
- [6] TEMT = tx_fifo_empty & !tx_busy.
- [7] = OE|PE|FE.
REQ-015 An LSR read returns the pre-clear value, then clears bits 1-4; an error pulse in the same cycle as the clearing read leaves that bit set.
REQ-016 THRE-pending flag:
- set on the rising edge of tx_fifo_empty while IER[1]=1;
- cleared by a THR write, or by an IIR read that returns 0xC2.
REQ-017 IIR fixed priority:
- 0xC6 when IER[2] & (OE|PE|FE|TXOVF);
- else 0xC4 when IER[0] & DR;
- else 0xC2 when THRE-pending;
- else 0xC1.
REQ-018 irq = !IIR[0], registered; it follows its cause with 1 cycle of latency.

Reset
REQ-019 While rst=1 at a clk edge, registers take these values:
- LCR=0, MCR=0, IER=0, SCR=0;
- {DLH,DLL}=DIV_RESET;
- sticky bits and THRE-pending = 0;
- all outputs 0, except divisor=DIV_RESET and lcr/mcr=0.
REQ-020 Reset asserted mid-operation discards any pending tx_wr_en/rx_rd_en/rd_valid pulse in that cycle; no FIFO side effect occurs after the reset edge.

Verification
REQ-021 Write LCR=0x80, DLL=0x00, DLH=0x00 -> divisor=1; then DLL=0x1B -> divisor=0x001B; LCR=0x03 -> addr 0 writes go to THR.
REQ-022 THR write 0xA5 with tx_fifo_full=0 -> tx_wr_en=1 and tx_data=0xA5 for one cycle; repeat with tx_fifo_full=1 -> no push, LSR read returns 0x10|THRE/TEMT bits, next LSR read has bit4=0.
REQ-023 rx_fifo_empty=0, rx_data=0x3C, read addr 0 -> rd_valid=1, rd_data=0x3C, rx_rd_en=1 for one cycle; with rx_fifo_empty=1 -> rd_data=0, rx_rd_en=0.
REQ-024 IER=0x07, rx_pe_p pulse and DR=1 together -> irq=1, IIR=0xC6; after an LSR read, IIR=0xC4; after rx_fifo_empty=1, IIR=0xC1 and irq=0.
REQ-025 rx_oe_p pulsed in the same cycle as an LSR read -> read shows OE as it was before, and OE=1 afterwards; simultaneous wr_en+rd_en to SCR -> SCR updated, rd_valid=0.

Source files
------------

// File: rtl/uart_regif_v2_if.sv
// Host register bus for the UART register interface.
//   wr_en    : write strobe (one cycle per write)
//   rd_en    : read strobe (one cycle per read)
//   addr     : 3-bit register address
//   data_in  : write data
//   rd_data  : read data, valid only while rd_valid is high (0 otherwise)
//   rd_valid : one-cycle pulse, one cycle after the accepted read strobe
// The master modport is the host side; the slave modport is the register block.
interface uart_regif_v2_if;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output wr_en, rd_en, addr, data_in,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, data_in,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/uart_regif_v2.sv
// 16550-style UART register block: decodes host reads/writes, drives TX/RX
// FIFO push/pop/flush strobes, holds LCR/MCR/IER/SCR/divisor, tracks sticky
// line-status errors and produces the prioritised IIR and a registered irq.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : host register bus (see uart_regif_v2_if)
//   tx_fifo_full/empty  : TX FIFO status; tx_busy : TX shifter active
//   tx_wr_en, tx_data   : TX FIFO push strobe and data
//   rx_fifo_empty       : RX FIFO status; rx_data : FWFT head of RX FIFO
//   rx_rd_en            : RX FIFO pop strobe
//   rx_oe_p/pe_p/fe_p   : overrun / parity / framing error pulses
//   tx_fifo_clr/rx_fifo_clr : FIFO flush pulses
//   divisor, lcr, mcr   : configuration outputs
//   irq                 : interrupt request
module uart_regif_v2 #(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 1,
  parameter int SCR_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_regif_v2_if.slave   bus,
  input  logic             tx_fifo_full,
  input  logic             tx_fifo_empty,
  input  logic             tx_busy,
  output logic             tx_wr_en,
  output logic [7:0]       tx_data,
  input  logic             rx_fifo_empty,
  input  logic [7:0]       rx_data,
  output logic             rx_rd_en,
  input  logic             rx_oe_p,
  input  logic             rx_pe_p,
  input  logic             rx_fe_p,
  output logic             tx_fifo_clr,
  output logic             rx_fifo_clr,
  output logic [DIV_W-1:0] divisor,
  output logic [7:0]       lcr,
  output logic [7:0]       mcr,
  output logic             irq
);

  localparam logic [DIV_W-1:0] DIV_TRUNC = DIV_W'(DIV_RESET);
  // A zero reset divisor would stall the baud generator, so it becomes 1.
  localparam logic [DIV_W-1:0] DIV_INIT  = (DIV_TRUNC == '0) ? DIV_W'(1) : DIV_TRUNC;

  localparam logic [7:0] IIR_LS   = 8'hC6;
  localparam logic [7:0] IIR_RX   = 8'hC4;
  localparam logic [7:0] IIR_THRE = 8'hC2;
  localparam logic [7:0] IIR_NONE = 8'hC1;

  // Truncate a {DLH,DLL} candidate to DIV_W bits and never allow zero.
  function automatic logic [DIV_W-1:0] div_clamp(input logic [15:0] v);
    logic [DIV_W-1:0] t;
    t = v[DIV_W-1:0];
    return (t == '0) ? DIV_W'(1) : t;
  endfunction

  logic [3:0] ier;
  logic [7:0] scr;
  logic       oe, pe, fe, txovf;
  logic       thre_pend;
  logic       tx_empty_q;

  logic       dlab;
  logic       wr, rd;
  logic       thr_wr, dll_wr, ier_wr, dlh_wr, fcr_wr, lcr_wr, mcr_wr, scr_wr;
  logic       rbr_rd, iir_rd, lsr_rd;
  logic [7:0] dll_rd, dlh_rd;
  logic [7:0] lsr, iir, rd_mux;

  assign dlab = lcr[7];
  assign wr   = bus.wr_en;
  // A read strobe coinciding with a write is dropped entirely.
  assign rd   = bus.rd_en & ~bus.wr_en;

  assign thr_wr = wr & (bus.addr == 3'd0) & ~dlab;
  assign dll_wr = wr & (bus.addr == 3'd0) &  dlab;
  assign ier_wr = wr & (bus.addr == 3'd1) & ~dlab;
  assign dlh_wr = wr & (bus.addr == 3'd1) &  dlab;
  assign fcr_wr = wr & (bus.addr == 3'd2);
  assign lcr_wr = wr & (bus.addr == 3'd3);
  assign mcr_wr = wr & (bus.addr == 3'd4);
  assign scr_wr = wr & (bus.addr == 3'd7);

  assign rbr_rd = rd & (bus.addr == 3'd0) & ~dlab;
  assign iir_rd = rd & (bus.addr == 3'd2);
  assign lsr_rd = rd & (bus.addr == 3'd5);

  // DLH only stores the bits that fit in DIV_W; the rest read back as 0.
  assign dll_rd = divisor[7:0];
  assign dlh_rd = 8'(divisor >> 8);

  assign lsr = {oe | pe | fe, tx_fifo_empty & ~tx_busy, ~tx_fifo_full,
                txovf, fe, pe, oe, ~rx_fifo_empty};

  always_comb begin
    iir = IIR_NONE;
    if (ier[2] & (oe | pe | fe | txovf)) iir = IIR_LS;
    else if (ier[0] & ~rx_fifo_empty)    iir = IIR_RX;
    else if (thre_pend)                  iir = IIR_THRE;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      3'd0:    rd_mux = dlab ? dll_rd : (rx_fifo_empty ? 8'h00 : rx_data);
      3'd1:    rd_mux = dlab ? dlh_rd : {4'b0000, ier};
      3'd2:    rd_mux = iir;
      3'd3:    rd_mux = lcr;
      3'd4:    rd_mux = mcr;
      3'd5:    rd_mux = lsr;
      3'd7:    rd_mux = scr;
      default: rd_mux = '0;
    endcase
  end

  if (SCR_EN != 0) begin : g_scr
    always_ff @(posedge clk) begin
      if (rst)         scr <= '0;
      else if (scr_wr) scr <= bus.data_in;
    end
  end else begin : g_no_scr
    assign scr = '0;
  end

  // Stage p1: every host-visible effect lands one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      tx_wr_en     <= 1'b0;
      tx_data      <= '0;
      rx_rd_en     <= 1'b0;
      tx_fifo_clr  <= 1'b0;
      rx_fifo_clr  <= 1'b0;
      divisor      <= DIV_INIT;
      lcr          <= '0;
      mcr          <= '0;
      ier          <= '0;
      oe           <= 1'b0;
      pe           <= 1'b0;
      fe           <= 1'b0;
      txovf        <= 1'b0;
      thre_pend    <= 1'b0;
      tx_empty_q   <= 1'b0;
      irq          <= 1'b0;
    end else begin
      bus.rd_valid <= rd;
      bus.rd_data  <= rd ? rd_mux : 8'h00;
      rx_rd_en     <= rbr_rd & ~rx_fifo_empty;
      tx_wr_en     <= thr_wr & ~tx_fifo_full;
      if (thr_wr & ~tx_fifo_full) tx_data <= bus.data_in;
      tx_fifo_clr  <= fcr_wr & bus.data_in[2];
      rx_fifo_clr  <= fcr_wr & bus.data_in[1];

      if (lcr_wr) lcr <= bus.data_in;
      if (mcr_wr) mcr <= bus.data_in;
      if (ier_wr) ier <= bus.data_in[3:0];
      if (dll_wr) divisor <= div_clamp({dlh_rd, bus.data_in});
      if (dlh_wr) divisor <= div_clamp({bus.data_in, dll_rd});

      // Clear-on-read first, then OR in new events so a same-cycle pulse survives.
      oe    <= (oe    & ~lsr_rd) | rx_oe_p;
      pe    <= (pe    & ~lsr_rd) | rx_pe_p;
      fe    <= (fe    & ~lsr_rd) | rx_fe_p;
      txovf <= (txovf & ~lsr_rd) | (thr_wr & tx_fifo_full);

      tx_empty_q <= tx_fifo_empty;
      if (thr_wr | (iir_rd & (iir == IIR_THRE)))
        thre_pend <= 1'b0;
      else if (tx_fifo_empty & ~tx_empty_q & ier[1])
        thre_pend <= 1'b1;

      irq <= ~iir[0];
    end
  end

endmodule
